// File: rtl/vrom_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// vrom_pixel_scheduler
//
// Drives the shared video ROM pair for VGA scan-out:
//   * interface ROM : 640x480 background, 6-bit RRGGBB, 1-cycle registered read
//   * digit ROM     : 40x600 sheet of ten 40x60 glyphs (0..9 stacked vertically)
// Every cycle the incoming pixel coordinate is turned into both ROM addresses.
// NUM_DIGITS glyphs are overlaid on the background. The overlay decision is
// pipelined so that it lines up with the ROM read latency. The total latency
// from pixel coordinate to rgb_out is a fixed 3 cycles, with one pixel per
// cycle and no stalls.
//
// Pipeline
//   stage 1 : ROM addresses plus hit/visible/video_on/sync flags are registered
//   stage 2 : ROM data is valid; the flags and sync are delayed one more cycle
//   stage 3 : rgb_out and sync_out are registered
//
// Optional feature (compile-time macro DIGIT_BLINK_EN):
//   When defined, a frame counter toggles a blink phase every BLINK_FRAMES
//   frames. While the phase is 1, digits selected by blink_mask are hidden.
//   When undefined, blink_mask is accepted but has no effect.
//
// Ports
//   CLK, RESET        pixel clock; synchronous active-high reset
//   pixel_x/pixel_y   current column/row from the sync generator
//   video_on          active-area flag
//   sync_in           {hsync,vsync}
//   digits_in         BCD digit values, digit 0 at [3:0]
//   digits_load       load request pulse
//   digits_busy       a captured load is waiting for the next frame start
//   digits_applied    1-cycle pulse when captured values become active
//   blink_mask        per-digit blink enable (DIGIT_BLINK_EN only)
//   addr_interfaz     interface ROM address;  data_interfaz  its read data
//   addr_numeros      digit ROM address;      data_numeros   its read data
//   rgb_out           final pixel colour
//   sync_out          sync_in delayed to line up with rgb_out
//   load_state_dbg    current state of the load handshake FSM (debug)
// ---------------------------------------------------------------------------
module vrom_pixel_scheduler #(
  parameter int          NUM_DIGITS   = 6,
  parameter int          DIG_X0       = 200,
  parameter int          DIG_Y0       = 210,
  parameter int          DIG_PITCH    = 44,
  parameter logic [5:0]  KEY_COLOR    = 6'b000011,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      video_on,
  input  logic [1:0]                sync_in,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      digits_load,
  output logic                      digits_busy,
  output logic                      digits_applied,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [18:0]               addr_interfaz,
  input  logic [5:0]                data_interfaz,
  output logic [14:0]               addr_numeros,
  input  logic [5:0]                data_numeros,
  output logic [5:0]                rgb_out,
  output logic [1:0]                sync_out,
  output logic                      load_state_dbg
);

  localparam int GLYPH_W = 40;
  localparam int GLYPH_H = 60;
  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;

  // -------------------------------------------------------------------------
  // Frame start: the first active pixel of a frame. Active digit values and
  // the blink counter only ever change here, so a frame is never torn.
  // -------------------------------------------------------------------------
  logic frame_start;
  assign frame_start = video_on && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // -------------------------------------------------------------------------
  // Digit load handshake.
  // Handshake: digits_load is a request that is accepted only while
  // digits_busy is low; on acceptance digits_in is captured into the shadow
  // register and digits_busy rises on the next cycle. While digits_busy is
  // high, further requests are dropped without capture. At the next frame
  // start, the shadow is copied to the active set, digits_applied pulses
  // for one cycle, and digits_busy falls at the same time.
  // A request that arrives on the frame-start cycle itself while idle is
  // only captured; it is applied at the following frame start.
  // -------------------------------------------------------------------------
  typedef enum logic {
    LD_IDLE    = 1'b0,
    LD_PENDING = 1'b1
  } ld_state_t;

  ld_state_t ld_state;
  ld_state_t ld_state_nx;
  logic      ld_capture;
  logic      ld_apply;

  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [4*NUM_DIGITS-1:0] active_digits;

  always_comb begin
    ld_state_nx = ld_state;
    ld_capture  = 1'b0;
    ld_apply    = 1'b0;
    case (ld_state)
      LD_IDLE: begin
        if (digits_load) begin
          ld_capture  = 1'b1;
          ld_state_nx = LD_PENDING;
        end
      end
      LD_PENDING: begin
        if (frame_start) begin
          ld_apply    = 1'b1;
          ld_state_nx = LD_IDLE;
        end
      end
      default: ld_state_nx = LD_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ld_state       <= LD_IDLE;
      shadow_digits  <= '1;
      active_digits  <= '1;
      digits_applied <= 1'b0;
    end else begin
      ld_state       <= ld_state_nx;
      digits_applied <= ld_apply;
      if (ld_capture) shadow_digits <= digits_in;
      if (ld_apply)   active_digits <= shadow_digits;
    end
  end

  assign digits_busy    = (ld_state == LD_PENDING);
  assign load_state_dbg = ld_state;

  // -------------------------------------------------------------------------
  // Per-digit blanking mask. A bit set here hides that digit regardless
  // of its value.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] blank_mask;

`ifdef DIGIT_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // The count runs 0..BLINK_FRAMES-1 and advances once per frame. The phase
  // flips on each wrap, so each half-period lasts BLINK_FRAMES frames.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank_mask = blink_phase ? blink_mask : '0;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blank_mask        = '0;
`endif

  // -------------------------------------------------------------------------
  // Stage 1 combinational: ROM addresses and overlay flags.
  // -------------------------------------------------------------------------
  int xi;
  int yi;
  assign xi = {22'd0, pixel_x};
  assign yi = {22'd0, pixel_y};

  logic        in_range;
  logic [18:0] addr_if_c;
  logic        hit_c;
  logic        vis_c;
  logic [3:0]  dig_c;
  logic [5:0]  dx_c;
  logic [5:0]  dy_c;
  logic [14:0] addr_num_c;

  assign in_range  = (xi < SCR_W) && (yi < SCR_H);
  assign addr_if_c = 19'(yi * SCR_W + xi);

  // Fields never overlap because DIG_PITCH >= glyph width, so at most one
  // iteration can match.
  always_comb begin
    hit_c      = 1'b0;
    vis_c      = 1'b0;
    dig_c      = 4'hF;
    dx_c       = '0;
    dy_c       = '0;
    addr_num_c = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((yi >= DIG_Y0) && (yi < DIG_Y0 + GLYPH_H) &&
          (xi >= DIG_X0 + k * DIG_PITCH) &&
          (xi <  DIG_X0 + k * DIG_PITCH + GLYPH_W)) begin
        hit_c = 1'b1;
        dig_c = active_digits[4*k +: 4];
        vis_c = (active_digits[4*k +: 4] <= 4'd9) && !blank_mask[k];
        dx_c  = 6'(xi - (DIG_X0 + k * DIG_PITCH));
        dy_c  = 6'(yi - DIG_Y0);
      end
    end
    // Glyph d lives at rows d*60 .. d*60+59 of the sheet.
    if (hit_c) begin
      addr_num_c = 15'((int'(dig_c) * GLYPH_H + int'(dy_c)) * GLYPH_W + int'(dx_c));
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic       s1_hit;
  logic       s1_vis;
  logic       s1_von;
  logic [1:0] s1_sync;
  logic       s2_hit;
  logic       s2_vis;
  logic       s2_von;
  logic [1:0] s2_sync;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_interfaz <= '0;
      addr_numeros  <= '0;
      s1_hit        <= 1'b0;
      s1_vis        <= 1'b0;
      s1_von        <= 1'b0;
      s1_sync       <= '0;
      s2_hit        <= 1'b0;
      s2_vis        <= 1'b0;
      s2_von        <= 1'b0;
      s2_sync       <= '0;
    end else begin
      addr_interfaz <= addr_if_c;
      addr_numeros  <= addr_num_c;
      s1_hit        <= hit_c;
      s1_vis        <= vis_c;
      // Coordinates outside the 640x480 area are never shown.
      s1_von        <= video_on && in_range;
      s1_sync       <= sync_in;
      s2_hit        <= s1_hit;
      s2_vis        <= s1_vis;
      s2_von        <= s1_von;
      s2_sync       <= s1_sync;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: colour mux. KEY_COLOR in the digit sheet is transparent.
  // -------------------------------------------------------------------------
  logic [5:0] rgb_nx;

  always_comb begin
    rgb_nx = data_interfaz;
    if (!s2_von) begin
      rgb_nx = '0;
    end else if (s2_hit && s2_vis && (data_numeros != KEY_COLOR)) begin
      rgb_nx = data_numeros;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgb_out  <= '0;
      sync_out <= '0;
    end else begin
      rgb_out  <= rgb_nx;
      sync_out <= s2_sync;
    end
  end

endmodule
